// File: rtl/bram_sp_be.sv
// Single-port block RAM with byte-lane write enables, selectable write mode,
// 1- or 2-cycle read latency, req/ready/rvalid handshake and optional zero-clear after reset.
module bram_sp_be #(
    parameter int    WIDTH          = 32,
    parameter int    DEPTH          = 1024,
    parameter int    READ_LATENCY   = 1,
    parameter string WRITE_MODE     = "READ_FIRST",
    parameter bit    CLEAR_ON_RESET = 1'b0,
    parameter string INIT_FILE      = "",
    localparam int   ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int   BE_W           = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [WIDTH-1:0]  rdata
);

    localparam logic              MODE_WF = (WRITE_MODE == "WRITE_FIRST");
    localparam logic              MODE_NC = (WRITE_MODE == "NO_CHANGE");
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              v1_q;
    logic [WIDTH-1:0]  d1_q;
    logic              rvalid_q;
    logic [WIDTH-1:0]  rdata_q;

    logic              acc_rd;
    logic              acc_wr;
    logic              in_range;
    logic [WIDTH-1:0]  old_word;
    logic              resp_vld_d;
    logic [WIDTH-1:0]  resp_dat_d;

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                     input logic [WIDTH-1:0] new_w,
                                                     input logic [BE_W-1:0]  lanes);
        logic [WIDTH-1:0] m;
        m = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (lanes[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                m[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return m;
    endfunction

    assign ready  = (state_q == S_RUN) && !rst;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

    // Decode the accepted access and form the response word for this edge
    always_comb begin
        acc_rd     = req && ready && !we;
        acc_wr     = req && ready && we;
        in_range   = ({1'b0, addr} < DEPTH_W);
        old_word   = in_range ? mem_q[addr] : '0;
        resp_vld_d = acc_rd || (acc_wr && !MODE_NC);
        if (acc_wr && MODE_WF) begin
            resp_dat_d = in_range ? merge_lanes(old_word, wdata, be) : '0;
        end else begin
            resp_dat_d = old_word;
        end
    end

    // Memory array: clear sweep or byte-lane write, out-of-range writes dropped
    always_ff @(posedge clk) begin
        if ((state_q == S_CLEAR) && !rst) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (acc_wr && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: CLEAR sweeps every word once, then RUN accepts requests
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == LAST_A) begin
                        state_q <= S_RUN;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q   <= S_RUN;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    // Response pipeline; reset flushes every stage so in-flight reads never complete
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            d1_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (READ_LATENCY >= 2) begin
            v1_q     <= resp_vld_d;
            if (resp_vld_d) begin
                d1_q <= resp_dat_d;
            end
            rvalid_q <= v1_q;
            if (v1_q) begin
                rdata_q <= d1_q;
            end
        end else begin
            v1_q     <= 1'b0;
            rvalid_q <= resp_vld_d;
            if (resp_vld_d) begin
                rdata_q <= resp_dat_d;
            end
        end
    end

endmodule
